// File: rtl/rom_ser_pkg.sv
// Shared types and constants for the record ROM serializer.
// Record geometry and sequencer state encoding.
package rom_ser_pkg;

  localparam int REC_W       = 14;
  localparam int ADDR_W      = 3;
  localparam int NUM_ROM_REC = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PAR,
    S_DONE
  } ser_state_t;

endpackage

// File: rtl/rec_shifter.sv
// Record load/shift register with even-parity capture and bit counter.
// Load takes priority over shift; the counter tracks the bit on msb_o.
module rec_shifter #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o,
  output logic         parity_o,
  output logic         first_o,
  output logic         last_bit_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      par_d   = ^data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
    end
  end

  assign msb_o      = shreg_q[W-1];
  assign parity_o   = par_q;
  assign first_o    = (cnt_q == '0);
  assign last_bit_o = (cnt_q == LAST);

endmodule

// File: rtl/rom_rec_serializer.sv
// Walks a run of ROM addresses and streams each record MSB-first
// followed by an even-parity bit over a valid/ready serial link.
module rom_rec_serializer #(
  parameter int REC_W  = 14,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   num_rec,
  output logic [ADDR_W-1:0] addrRom,
  input  logic [REC_W-1:0]  recRom,
  output logic              ser_bit,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy,
  output logic              done
);

  import rom_ser_pkg::*;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

  ser_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              load, shift;
  logic              msb, parity, first_bit, last_bit;

  rec_shifter #(.W(REC_W)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_i    (shift),
    .data_i     (recRom),
    .msb_o      (msb),
    .parity_o   (parity),
    .first_o    (first_bit),
    .last_bit_o (last_bit)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = first_addr;
          rem_d   = num_rec;
          state_d = (num_rec == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (ser_ready) begin
          shift = 1'b1;
          if (last_bit) state_d = S_PAR;
        end
      end
      S_PAR: begin
        if (ser_ready) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_ONE) begin
            state_d = S_DONE;
          end else begin
            // Natural overflow of the address gives the 7 -> 0 wrap.
            addr_d  = addr_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign addrRom   = addr_q;
  assign ser_valid = (state_q == S_SHIFT) || (state_q == S_PAR);
  assign ser_bit   = ((state_q == S_SHIFT) && msb) ||
                     ((state_q == S_PAR) && parity);
  assign ser_first = (state_q == S_SHIFT) && first_bit;
  assign ser_last  = (state_q == S_PAR);
  assign busy      = (state_q == S_LOAD) || ser_valid;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_rom_rec_serializer.sv
// Directed bench for rom_rec_serializer with a behavioural 8x14 ROM.
// Cycle n is the interval after the n-th edge following start.
module tb_rom_rec_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  first_addr;
  logic [3:0]  num_rec;
  logic [2:0]  addrRom;
  logic [13:0] recRom;
  logic        ser_bit, ser_valid, ser_ready;
  logic        ser_first, ser_last, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [13:0] rom_f(input logic [2:0] a);
    case (a)
      3'd0: rom_f = 14'b01010101010101;
      3'd1: rom_f = 14'b11110000111100;
      3'd2: rom_f = 14'b00110011001100;
      3'd3: rom_f = 14'b10001010010100;
      3'd4: rom_f = 14'b00000100001100;
      3'd5: rom_f = 14'b11111111111111;
      3'd6: rom_f = 14'b00000001101100;
      default: rom_f = 14'b10000000000001;
    endcase
  endfunction

  assign recRom = rom_f(addrRom);

  rom_rec_serializer #(.REC_W(14), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .num_rec    (num_rec),
    .addrRom    (addrRom),
    .recRom     (recRom),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rdy;
    logic [2:0] addr;
    logic       valid;
    logic       sbit;
    logic       first;
    logic       last;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t vecs[18];

  bit         bits_q[$];
  bit         firsts_q[$];
  bit         lasts_q[$];
  logic [2:0] addrs_q[$];
  int busy_n, busy_lo, busy_hi, valid_n, done_n, done_cyc, stall_err;

  function automatic bit exp_bit(input logic [2:0] fa, input int k);
    logic [2:0]  a;
    logic [13:0] r;
    int          pos;
    a   = fa + 3'(k / 15);
    r   = rom_f(a);
    pos = k % 15;
    exp_bit = (pos < 14) ? r[13-pos] : ^r;
  endfunction

  task automatic run(input logic [2:0] fa, input logic [3:0] n,
                     input bit rnd, input int poke);
    int  cyc;
    bit  ended, pv, phs, pb;
    bits_q.delete(); firsts_q.delete(); lasts_q.delete();
    addrs_q.delete();
    busy_n = 0; busy_lo = 0; busy_hi = 0; valid_n = 0;
    done_n = 0; done_cyc = 0; stall_err = 0;
    pv = 0; phs = 0; pb = 0; ended = 0;
    first_addr = fa; num_rec = n; start = 1'b1; ser_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!ended && cyc < 3000) begin
      ser_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = (cyc == poke);
      first_addr = (cyc == poke) ? 3'd5 : fa;
      if (pv && !phs && (!ser_valid || ser_bit !== pb)) stall_err++;
      if (busy) begin
        busy_n++;
        if (busy_lo == 0) busy_lo = cyc;
        busy_hi = cyc;
      end
      if (ser_valid) valid_n++;
      if (busy && !ser_valid) addrs_q.push_back(addrRom);
      if (ser_valid && ser_ready) begin
        bits_q.push_back(ser_bit);
        firsts_q.push_back(ser_first);
        lasts_q.push_back(ser_last);
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end else if (done_n > 0) begin
        ended = 1;
      end
      pv = ser_valid; phs = ser_valid && ser_ready; pb = ser_bit;
      if (!ended) begin
        step();
        cyc++;
      end
    end
    start = 1'b0; ser_ready = 1'b1;
    chk("run_terminates", 32'(ended), 32'd1);
  endtask

  function automatic int stream_err(input logic [2:0] fa);
    int e = 0;
    foreach (bits_q[i]) begin
      if (bits_q[i] != exp_bit(fa, i)) e++;
      if (firsts_q[i] != (i % 15 == 0)) e++;
      if (lasts_q[i] != (i % 15 == 14)) e++;
    end
    return e;
  endfunction

  function automatic logic [14:0] first15();
    logic [14:0] v = '0;
    for (int i = 0; i < 15 && i < bits_q.size(); i++)
      v[14-i] = bits_q[i];
    return v;
  endfunction

  initial begin
    logic [13:0] r0;
    r0 = 14'b01010101010101;
    for (int c = 0; c < 18; c++) begin
      vecs[c] = '{rdy: 1'b1, addr: 3'd0, valid: 1'b0, sbit: 1'b0,
                  first: 1'b0, last: 1'b0, bsy: 1'b0, dn: 1'b0};
      if (c == 0) vecs[c].bsy = 1'b1;
      if (c >= 1 && c <= 14) begin
        vecs[c].valid = 1'b1;
        vecs[c].sbit  = r0[14-c];
        vecs[c].first = (c == 1);
        vecs[c].bsy   = 1'b1;
      end
      if (c == 15) begin
        vecs[c].valid = 1'b1;
        vecs[c].sbit  = 1'b1;
        vecs[c].last  = 1'b1;
        vecs[c].bsy   = 1'b1;
      end
      if (c == 16) vecs[c].dn = 1'b1;
    end

    rst = 1'b1; start = 1'b0; first_addr = 3'd0; num_rec = 4'd0;
    ser_ready = 1'b1;
    step(); step();
    chk("rst_valid", 32'(ser_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(addrRom), 0);
    chk("rst_bit_first_last", 32'({ser_bit, ser_first, ser_last}), 0);
    rst = 1'b0;
    step();

    // record 0, one per cycle from the LOAD cycle
    first_addr = 3'd0; num_rec = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      ser_ready = vecs[c].rdy;
      chk($sformatf("t1_c%0d", c + 1),
          32'({addrRom, ser_valid, ser_valid ? ser_bit : 1'b0,
               ser_first, ser_last, busy, done}),
          32'({vecs[c].addr, vecs[c].valid, vecs[c].sbit,
               vecs[c].first, vecs[c].last, vecs[c].bsy, vecs[c].dn}));
      step();
    end

    // wrap-around 6, 7, 0
    run(3'd6, 4'd3, 1'b0, -1);
    chk("t2_nbits", bits_q.size(), 45);
    chk("t2_rec6", 32'(first15()), 32'(15'b000000011011000));
    chk("t2_stream", stream_err(3'd6), 0);
    chk("t2_addrs", 32'({addrs_q.size() == 3 ? addrs_q[0] : 3'd1,
                         addrs_q.size() == 3 ? addrs_q[1] : 3'd1,
                         addrs_q.size() == 3 ? addrs_q[2] : 3'd1}),
        32'({3'd6, 3'd7, 3'd0}));
    chk("t2_done_cyc", done_cyc, 49);

    // full sweep of all eight records
    run(3'd0, 4'd8, 1'b0, -1);
    chk("t3_nbits", bits_q.size(), 120);
    chk("t3_stream", stream_err(3'd0), 0);
    chk("t3_busy_n", busy_n, 128);
    chk("t3_busy_lo", busy_lo, 1);
    chk("t3_busy_hi", busy_hi, 128);
    chk("t3_done_n", done_n, 1);
    chk("t3_done_cyc", done_cyc, 129);

    // random backpressure on record 3
    run(3'd3, 4'd1, 1'b1, -1);
    chk("t4_stream", 32'(first15()), 32'(15'b100010100101001));
    chk("t4_nbits", bits_q.size(), 15);
    chk("t4_stall_stable", stall_err, 0);
    chk("t4_done_n", done_n, 1);

    // empty run
    run(3'd2, 4'd0, 1'b0, -1);
    chk("t5_done_cyc", done_cyc, 1);
    chk("t5_valid_n", valid_n, 0);
    chk("t5_busy_n", busy_n, 0);

    // start while busy is ignored
    run(3'd0, 4'd1, 1'b0, 5);
    chk("t5_ign_stream", 32'(first15()), 32'(15'b010101010101011));
    chk("t5_ign_done_n", done_n, 1);
    step(); step();
    chk("t5_ign_idle", 32'({busy, ser_valid, done}), 0);

    // async reset during 7th bit of record 4 (second record of 3..5)
    first_addr = 3'd3; num_rec = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 24; c++) step();
    chk("t6_pre_addr", 32'(addrRom), 4);
    chk("t6_pre_valid", 32'(ser_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_out",
        32'({addrRom, ser_bit, ser_valid, ser_first, ser_last, busy, done}),
        0);
    step();
    rst = 1'b0;
    step();
    run(3'd4, 4'd1, 1'b0, -1);
    chk("t6_replay", 32'(first15()), 32'(15'b000001000011001));
    chk("t6_replay_first", 32'(firsts_q.size() > 0 ? firsts_q[0] : 1'b0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
